pipe_dff_chain: RTL and testbench
=================================

// Module: pipe_dff_chain
// PURPOSE
//  Parametrised multi-stage enabled register pipeline with per-stage valid tracking.
//  Generalises the single enabled async-reset flop to WIDTH bits x DEPTH stages.
//  Adds a global stall (en), a synchronous flush and a pipeline-busy indication.
//  Used to retime/delay datapaths between blocks without a full FIFO handshake.
// PARAMETERS
//  WIDTH    8    data bits per stage (>=1)
//  DEPTH    3    number of register stages = latency in enabled cycles (>=1)
//  RST_VAL  0    WIDTH-bit value loaded into every data stage on reset
// PORTS
//  clk      in   1                 system clock, posedge
//  rst      in   1                 reset, asynchronous, active-low
//  en       in   1                 advance enable; 0 = stall (all stages hold)
//  flush    in   1                 synchronous flush, clears all valids
//  in_vld   in   1                 d is valid this cycle
//  d        in   WIDTH             input data
//  q        out  WIDTH             data of last stage
//  out_vld  out  1                 valid of last stage
//  busy     out  1                 OR of all stage valids
//  occ      out  $clog2(DEPTH+1)   valid-stage count (only with PIPE_DFF_OCC_EN)
// BEHAVIOUR
//  Reset (rst=0, async, no clk needed): all data stages=RST_VAL, all valids=0,
//   q=RST_VAL, out_vld=0, busy=0, occ=0. Release is sampled on next posedge.
//  Stage s[0..DEPTH-1], valid v[0..DEPTH-1]; q=s[DEPTH-1], out_vld=v[DEPTH-1].
//  Priority per posedge: flush > en > hold.
//  flush=1: every v[i]<=0 regardless of en/in_vld; data regs hold (not cleared).
//  flush=0, en=1: s[0]<=d, v[0]<=in_vld; s[i]<=s[i-1], v[i]<=v[i-1] for i>=1.
//   Data shifts even when in_vld=0 (bubbles carry stale data, valid=0).
//  flush=0, en=0: all s and v hold; d/in_vld ignored (input lost, no backpressure).
//  Latency: word accepted at edge N (en=1) appears on q with out_vld=1 after
//   DEPTH enabled edges; stalled cycles add 1 cycle each.
//  busy is combinational OR of registered valids (no comb path from inputs).
//  q, out_vld have no combinational path from d, in_vld, en or flush.
//  DEPTH=1: behaves as single enabled flop plus valid bit.
//  Reset mid-operation: all in-flight words discarded immediately; nothing emitted.
//  X on d with in_vld=0 must not affect any valid/occ output.
// CONFIGURATION
//  PIPE_DFF_OCC_EN defined: registered occ counter, reset 0.
//   flush=1 -> occ<=0. flush=0,en=1 -> occ<=occ+in_vld-v[DEPTH-1]
//   (simultaneous in/out -> unchanged). en=0 -> hold. Never exceeds DEPTH,
//   never underflows; occ==popcount(v) at all times (assertion).
//  PIPE_DFF_OCC_EN undefined: occ port and counter absent; all other
//   behaviour identical.
// TESTING
//  WIDTH=8,DEPTH=3: rst=0 -> q=RST_VAL(0x00), out_vld=0, busy=0 without clk edge.
//  en=1, in_vld=1, d=0xA5 at edge0, in_vld=0 after -> q=0xA5,out_vld=1 after edge2
//   only (one cycle), busy=1 from edge0 until after edge3.
//  Stream 0x01,0x02,0x03 with en=0 for 2 cycles mid-stream -> outputs 01,02,03 in
//   order, each delayed 2 cycles past nominal, no duplicates or drops.
//  flush=1 with en=1,in_vld=1,d=0x55 while 2 words in flight -> next cycle busy=0,
//   out_vld=0 for 3 edges; 0x55 never emitted.
//  rst pulsed low between edges with 3 words in flight -> immediate out_vld=0,
//   busy=0, q=0x00; after release no stale word emerges.
//  PIPE_DFF_OCC_EN: continuous in_vld=1 -> occ 0,1,2,3,3..; stop input -> 3,2,1,0;
//   flush at occ=2 -> occ=0 next cycle; occ==popcount(v) every cycle.

Source files
------------

// File: rtl/pipe_dff_chain.sv
// DEPTH-stage, WIDTH-bit enabled register pipeline with a valid bit per stage, global stall, flush and busy.
// Define PIPE_DFF_OCC_EN to add the registered occupancy counter output occ.
module pipe_dff_chain #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             out_vld,
    output logic             busy
`ifdef PIPE_DFF_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

    // Flush wins over enable; the data path only moves when not flushing.
    logic advance;
    assign advance = en & ~flush;

    logic [DEPTH-1:0][WIDTH-1:0] s_chain;
    logic [DEPTH-1:0]            v_chain;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] s_q;
            logic [WIDTH-1:0] s_d;
            logic             v_q;
            logic             v_d;

            if (gi == 0) begin : g_head
                assign s_d = d;
                assign v_d = in_vld;
            end else begin : g_body
                assign s_d = s_chain[gi-1];
                assign v_d = v_chain[gi-1];
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s_q <= RST_VAL;
                end else if (advance) begin
                    s_q <= s_d;
                end
            end

            // Data is left untouched by flush; only the valids are dropped.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v_q <= 1'b0;
                end else if (flush) begin
                    v_q <= 1'b0;
                end else if (en) begin
                    v_q <= v_d;
                end
            end

            assign s_chain[gi] = s_q;
            assign v_chain[gi] = v_q;
        end
    endgenerate

    assign q       = s_chain[DEPTH-1];
    assign out_vld = v_chain[DEPTH-1];
    assign busy    = |v_chain;

`ifdef PIPE_DFF_OCC_EN
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic [OCC_W-1:0] pop;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (en) begin
            if (in_vld && !v_chain[DEPTH-1]) begin
                occ_d = occ_q + OCC_W'(1);
            end else if (!in_vld && v_chain[DEPTH-1]) begin
                occ_d = occ_q - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;

    always_comb begin
        pop = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pop = pop + OCC_W'(v_chain[i]);
        end
    end

    // The counter is an incremental mirror of the valid bits and must never drift.
    a_occ_matches_valids: assert property (@(posedge clk) disable iff (!rst) occ_q == pop);
    a_occ_bounded:        assert property (@(posedge clk) disable iff (!rst) occ_q <= OCC_W'(DEPTH));
`endif

endmodule

// File: tb/tb_pipe_dff_chain.sv
// Directed bench for pipe_dff_chain (WIDTH=8, DEPTH=3): reset, latency, stall, flush, mid-flight reset, occ.
module tb_pipe_dff_chain;

    logic       clk;
    logic       rst;
    logic       en;
    logic       flush;
    logic       in_vld;
    logic [7:0] d;
    logic [7:0] q;
    logic       out_vld;
    logic       busy;
`ifdef PIPE_DFF_OCC_EN
    logic [1:0] occ;
`endif

    int checks_total;
    int errors_total;

    pipe_dff_chain #(
        .WIDTH  (8),
        .DEPTH  (3),
        .RST_VAL(8'h00)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .flush  (flush),
        .in_vld (in_vld),
        .d      (d),
        .q      (q),
        .out_vld(out_vld),
        .busy   (busy)
`ifdef PIPE_DFF_OCC_EN
        ,
        .occ    (occ)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp) begin
            errors_total++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one posedge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic f, input logic v, input logic [7:0] data);
        en     = e;
        flush  = f;
        in_vld = v;
        d      = data;
    endtask

    // Stall stream table: edges e0..e7
    logic       st_en   [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
    logic       st_vld  [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    logic [7:0] st_d    [8] = '{8'h01, 8'h02, 8'hEE, 8'hEE, 8'h03, 8'h00, 8'h00, 8'h00};
    logic       st_ovld [8] = '{0, 0, 0, 0, 1, 1, 1, 0};
    logic [7:0] st_q    [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
    logic       st_busy [8] = '{1, 1, 1, 1, 1, 1, 1, 0};

    initial begin
        checks_total = 0;
        errors_total = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);

        // Asynchronous reset before the first clock edge
        #1 rst = 1'b0;
        #1;
        check_val("rst_q", 32'(q), 32'h00);
        check_val("rst_out_vld", 32'(out_vld), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
`ifdef PIPE_DFF_OCC_EN
        check_val("rst_occ", 32'(occ), 32'h0);
`endif
        #1 rst = 1'b1;
        step();

        // Single word latency
        drive(1'b1, 1'b0, 1'b1, 8'hA5);
        step();
        check_val("lat_e0_out_vld", 32'(out_vld), 32'h0);
        check_val("lat_e0_busy", 32'(busy), 32'h1);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        check_val("lat_e1_out_vld", 32'(out_vld), 32'h0);
        check_val("lat_e1_busy", 32'(busy), 32'h1);
        step();
        check_val("lat_e2_q", 32'(q), 32'hA5);
        check_val("lat_e2_out_vld", 32'(out_vld), 32'h1);
        check_val("lat_e2_busy", 32'(busy), 32'h1);
        step();
        check_val("lat_e3_out_vld", 32'(out_vld), 32'h0);
        check_val("lat_e3_busy", 32'(busy), 32'h0);

        // Stream with two stalled cycles mid-stream
        for (int i = 0; i < 8; i++) begin
            drive(st_en[i], 1'b0, st_vld[i], st_d[i]);
            step();
            check_val($sformatf("stall_e%0d_out_vld", i), 32'(out_vld), 32'(st_ovld[i]));
            check_val($sformatf("stall_e%0d_busy", i), 32'(busy), 32'(st_busy[i]));
            if (st_ovld[i]) begin
                check_val($sformatf("stall_e%0d_q", i), 32'(q), 32'(st_q[i]));
            end
        end

        // Flush with two words in flight and a competing input word
        drive(1'b1, 1'b0, 1'b1, 8'h11);
        step();
        drive(1'b1, 1'b0, 1'b1, 8'h22);
        step();
        check_val("flush_pre_busy", 32'(busy), 32'h1);
        drive(1'b1, 1'b1, 1'b1, 8'h55);
        step();
        check_val("flush_busy", 32'(busy), 32'h0);
        check_val("flush_out_vld", 32'(out_vld), 32'h0);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        check_val("flush_a1_out_vld", 32'(out_vld), 32'h0);
        check_val("flush_a1_q_held", 32'(q), 32'h11);
        step();
        check_val("flush_a2_out_vld", 32'(out_vld), 32'h0);
        check_val("flush_a2_q_held", 32'(q), 32'h22);
        step();
        check_val("flush_a3_out_vld", 32'(out_vld), 32'h0);
        check_val("flush_a3_busy", 32'(busy), 32'h0);

        // Reset pulse between edges with three words in flight
        drive(1'b1, 1'b0, 1'b1, 8'h31);
        step();
        drive(1'b1, 1'b0, 1'b1, 8'h32);
        step();
        drive(1'b1, 1'b0, 1'b1, 8'h33);
        step();
        check_val("mrst_pre_q", 32'(q), 32'h31);
        check_val("mrst_pre_out_vld", 32'(out_vld), 32'h1);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        #1 rst = 1'b0;
        #1;
        check_val("mrst_out_vld", 32'(out_vld), 32'h0);
        check_val("mrst_busy", 32'(busy), 32'h0);
        check_val("mrst_q", 32'(q), 32'h00);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("mrst_post%0d_out_vld", i), 32'(out_vld), 32'h0);
            check_val($sformatf("mrst_post%0d_busy", i), 32'(busy), 32'h0);
        end

`ifdef PIPE_DFF_OCC_EN
        // Occupancy fill, drain and flush
        check_val("occ_start", 32'(occ), 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'(8'h40 + i));
            step();
            check_val($sformatf("occ_fill%0d", i), 32'(occ), 32'((i < 3) ? i + 1 : 3));
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00);
            step();
            check_val($sformatf("occ_drain%0d", i), 32'(occ), 32'(2 - i));
        end
        drive(1'b1, 1'b0, 1'b1, 8'h61);
        step();
        drive(1'b1, 1'b0, 1'b1, 8'h62);
        step();
        check_val("occ_pre_flush", 32'(occ), 32'h2);
        drive(1'b0, 1'b1, 1'b1, 8'h63);
        step();
        check_val("occ_flush", 32'(occ), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors_total, checks_total);
        $finish;
    end

endmodule
